sfu_ctrl: RTL
=============

# sfu_ctrl

Controller that sequences the special function unit (SFU) between the output FIFO (OFIFO) and the partial-sum memory (PMEM). It has two modes:
- **Store mode:** drains OFIFO partial sums through the SFU bypass path into PMEM.
- **Accumulate mode:** reads the NUM_ACC stored tiles per output pixel back out of PMEM, accumulates them in the SFU, fires the SFU ReLU cycle and writes the final result into the PMEM output region.

PMEM is single-port; this block is its only master while busy.

## Interface
Parameters:
- addr_bw, 11: PMEM address width.
- num_acc, 9: partial-sum tiles per output (kernel taps).
- num_out, 16: output pixels per tile.
- out_base, 1024: PMEM base address of the final-output region.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  launch an operation. Sampled only in IDLE.
- mode  in  1  0 = store, 1 = accumulate. Latched with start.
- ofifo_valid  in  1  OFIFO holds at least one row.
- ofifo_rd  out  1  OFIFO pop; data appears on the SFU input the next cycle.
- sfu_bypass  out  1  drives SFU bypass.
- sfu_acc  out  1  drives SFU acc.
- pmem_rd  out  1  PMEM read; data is valid the next cycle.
- pmem_wr  out  1  PMEM write of the current SFU output.
- pmem_addr  out  addr_bw  PMEM address for the rd/wr in the same cycle.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at completion.

## Operation
- States: IDLE, STORE, STORE_DRAIN, ACC_RD, ACC_LAST, RELU, WRITE, DONE.
- IDLE:
  - On start=1, latch mode and clear counters.
  - Go to STORE (mode=0) or ACC_RD (mode=1).
  - start while busy is ignored.
- STORE:
  - ofifo_rd = ofifo_valid && (pop count < num_acc*num_out).
  - sfu_bypass = ofifo_rd delayed 1 cycle.
  - pmem_wr = ofifo_rd delayed 2 cycles. pmem_addr = write count, sequential 0 .. num_acc*num_out-1.
  - Once the last pop is issued, go to STORE_DRAIN. It lasts exactly 2 cycles, letting the last write land, then goes to DONE.
  - ofifo_valid low stalls the pops; the delayed pipeline keeps draining.
- ACC_RD, for output o, tap k = 0 .. num_acc-1:
  - pmem_rd=1, pmem_addr = k*num_out + o.
  - The address is generated by adding num_out per tap; no multiplier.
  - After k = num_acc-1, go to ACC_LAST.
- sfu_acc = pmem_rd delayed 1 cycle. It is therefore high in ACC_RD cycles 1 .. num_acc-1 and in ACC_LAST.
- RELU: sfu_acc=0, sfu_bypass=0. The SFU registers ReLU(sum) and clears its accumulator.
- WRITE:
  - pmem_wr=1, pmem_addr = out_base + o.
  - o++. Go to ACC_RD if o < num_out, else DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- pmem_rd and pmem_wr are never high in the same cycle.
- Outside the cycles listed above, ofifo_rd, sfu_bypass, sfu_acc, pmem_rd and pmem_wr are 0.

## Timing
- Reset value of every output is 0; pmem_addr is 0; the state is IDLE.
- Reset mid-operation aborts immediately: all strobes drop in the same cycle and no further PMEM write occurs. The SFU is reset by its own reset.
- start at cycle t → busy=1 at t+1; the first ofifo_rd or pmem_rd is at t+1.
- Store latency with ofifo_valid held high: num_acc*num_out pops, then done at t + num_acc*num_out + 3.
- Accumulate: num_acc+3 cycles per output, so done at t + 1 + num_out*(num_acc+3).
- Counters are sized with $clog2 of their max+1. Addresses do not wrap; out_base + num_out must be ≤ 2^addr_bw. This is a static parameter constraint.

## Structure
- sfu_ctrl_pkg holds:
  - the state enum;
  - the MODE_STORE / MODE_ACC constants.
- One sub-module, sfu_ctrl_addr_gen: tap and output counters, the strided read address, and the out_base write address. It takes step/clear/next_out inputs.
- The FSM, the 2-deep store delay pipeline and the acc delay live in sfu_ctrl.

## Test plan
- Reset asserted mid-run, including mid-ACC_RD:
  - all outputs 0 asynchronously (before the next clk edge);
  - state IDLE;
  - a new start after reset runs cleanly.
- Store, num_acc=9, num_out=16, ofifo_valid=1:
  - 144 ofifo_rd pulses;
  - pmem_wr to addresses 0..143, each 2 cycles after its pop;
  - done at t+147.
- Store with ofifo_valid toggling 1/0 every cycle:
  - exactly 144 writes, with sequential addresses and no gaps in the address sequence;
  - sfu_bypass exactly 1 cycle after each pop.
- Accumulate, defaults:
  - output 0 reads addresses 0,16,…,128;
  - sfu_acc high 9 cycles;
  - one RELU cycle, then a write to 1024;
  - the last write goes to 1039;
  - done at t+193.
- start pulsed while busy is ignored, and mode changes mid-run are ignored.
- pmem_rd && pmem_wr is never high in the same cycle, checked across both modes.

Source files
------------

// File: rtl/sfu_ctrl_pkg.sv
// sfu_ctrl_pkg
// Shared types for the SFU controller: the FSM state encoding and the
// mode constants sampled together with start.
// No ports; imported by sfu_ctrl and its address generator.
package sfu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_STORE_DRAIN,
    S_ACC_RD,
    S_ACC_LAST,
    S_RELU,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic MODE_STORE = 1'b0;
  localparam logic MODE_ACC   = 1'b1;

endpackage

// File: rtl/sfu_ctrl_if.sv
// sfu_ctrl_if
// Bundles the command, OFIFO, SFU and PMEM strobes of the SFU controller.
// Signals:
//   start, mode, ofifo_valid        : towards the controller
//   ofifo_rd, sfu_bypass, sfu_acc   : OFIFO pop and SFU control
//   pmem_rd, pmem_wr, pmem_addr     : single-port PMEM access
//   busy, done                      : operation status
// Modports: master drives the command side, slave is the controller.
interface sfu_ctrl_if #(
  parameter int addr_bw = 11
);

  logic               start;
  logic               mode;
  logic               ofifo_valid;
  logic               ofifo_rd;
  logic               sfu_bypass;
  logic               sfu_acc;
  logic               pmem_rd;
  logic               pmem_wr;
  logic [addr_bw-1:0] pmem_addr;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output mode,
    output ofifo_valid,
    input  ofifo_rd,
    input  sfu_bypass,
    input  sfu_acc,
    input  pmem_rd,
    input  pmem_wr,
    input  pmem_addr,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  mode,
    input  ofifo_valid,
    output ofifo_rd,
    output sfu_bypass,
    output sfu_acc,
    output pmem_rd,
    output pmem_wr,
    output pmem_addr,
    output busy,
    output done
  );

endinterface

// File: rtl/sfu_ctrl_addr_gen.sv
// sfu_ctrl_addr_gen
// Tap/output counters and PMEM address generation for accumulate mode.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart at output 0, tap 0
//   step       : one tap read issued; advance to the next tap
//   next_out   : current output written; move to the next output pixel
//   rd_addr    : strided read address, tap*num_out + output
//   wr_addr    : final-result address, out_base + output
//   tap_last   : current tap is the last one of this output
//   out_last   : current output is the last one of the tile
module sfu_ctrl_addr_gen #(
  parameter int addr_bw  = 11,
  parameter int num_acc  = 9,
  parameter int num_out  = 16,
  parameter int out_base = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  input  logic               next_out,
  output logic [addr_bw-1:0] rd_addr,
  output logic [addr_bw-1:0] wr_addr,
  output logic               tap_last,
  output logic               out_last
);

  localparam int tap_w = $clog2(num_acc + 1);
  localparam int out_w = $clog2(num_out + 1);

  logic [tap_w-1:0] tap_cnt;
  logic [out_w-1:0] out_cnt;

  // The read address walks the tap stride by adding num_out each tap, so no
  // multiplier is needed. Moving to a new output re-bases it at that output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_cnt <= '0;
      out_cnt <= '0;
      rd_addr <= '0;
    end else if (clear) begin
      tap_cnt <= '0;
      out_cnt <= '0;
      rd_addr <= '0;
    end else if (next_out) begin
      tap_cnt <= '0;
      out_cnt <= out_cnt + out_w'(1);
      rd_addr <= addr_bw'(out_cnt) + addr_bw'(1);
    end else if (step) begin
      tap_cnt <= tap_cnt + tap_w'(1);
      rd_addr <= rd_addr + addr_bw'(num_out);
    end
  end

  assign wr_addr  = addr_bw'(out_base) + addr_bw'(out_cnt);
  assign tap_last = (tap_cnt == tap_w'(num_acc - 1));
  assign out_last = (out_cnt == out_w'(num_out - 1));

endmodule

// File: rtl/sfu_ctrl.sv
// sfu_ctrl
// Sequences the SFU between OFIFO and PMEM.
//   store mode      : OFIFO rows go through the SFU bypass into PMEM 0..N-1
//   accumulate mode : per output pixel, read all taps from PMEM, accumulate,
//                     fire ReLU, write the result to out_base + pixel
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sfu_ctrl_if slave (command, OFIFO, SFU and PMEM strobes)
// The interface instance must use the same addr_bw as this module.
module sfu_ctrl #(
  parameter int addr_bw  = 11,
  parameter int num_acc  = 9,
  parameter int num_out  = 16,
  parameter int out_base = 1024
) (
  input  logic        clk,
  input  logic        reset,
  sfu_ctrl_if.slave   bus
);

  import sfu_ctrl_pkg::*;

  localparam int total = num_acc * num_out;
  localparam int cnt_w = $clog2(total + 1);

  state_t             state;
  state_t             state_nxt;
  logic               busy_q;
  logic               done_q;
  logic               rd_q;
  logic               acc_wr_q;
  logic               drain_second;
  logic               byp_d;
  logic               wr_d;
  logic               acc_d;
  logic [cnt_w-1:0]   pop_cnt;
  logic [cnt_w-1:0]   wr_cnt;
  logic               launch;
  logic               ofifo_rd;
  logic               pop_last;
  logic               acc_step;
  logic               acc_next;
  logic [addr_bw-1:0] rd_addr;
  logic [addr_bw-1:0] wr_addr;
  logic [addr_bw-1:0] pmem_addr;
  logic               tap_last;
  logic               out_last;

  assign launch   = (state == S_IDLE) && bus.start;
  assign ofifo_rd = (state == S_STORE) && bus.ofifo_valid && (pop_cnt < cnt_w'(total));
  assign pop_last = (pop_cnt == cnt_w'(total - 1));
  assign acc_step = (state == S_ACC_RD);
  assign acc_next = (state == S_WRITE);

  sfu_ctrl_addr_gen #(
    .addr_bw  (addr_bw),
    .num_acc  (num_acc),
    .num_out  (num_out),
    .out_base (out_base)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (launch),
    .step     (acc_step),
    .next_out (acc_next),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .tap_last (tap_last),
    .out_last (out_last)
  );

  // Next-state logic. The mode input is only consulted on launch; after that
  // the state itself carries which mode is running, so later mode changes
  // have no effect.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:        if (bus.start) state_nxt = (bus.mode == MODE_ACC) ? S_ACC_RD : S_STORE;
      S_STORE:       if (ofifo_rd && pop_last) state_nxt = S_STORE_DRAIN;
      S_STORE_DRAIN: if (drain_second) state_nxt = S_DONE;
      S_ACC_RD:      if (tap_last) state_nxt = S_ACC_LAST;
      S_ACC_LAST:    state_nxt = S_RELU;
      S_RELU:        state_nxt = S_WRITE;
      S_WRITE:       state_nxt = out_last ? S_DONE : S_ACC_RD;
      S_DONE:        state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  // State register. The state-decoded outputs are registered from the next
  // state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_q         <= 1'b0;
      acc_wr_q     <= 1'b0;
      drain_second <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy_q       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done_q       <= (state_nxt == S_DONE);
      rd_q         <= (state_nxt == S_ACC_RD);
      acc_wr_q     <= (state_nxt == S_WRITE);
      drain_second <= (state == S_STORE_DRAIN) && !drain_second;
    end
  end

  // Store pipeline: a pop lands on the SFU input one cycle later (bypass) and
  // the SFU output is ready for PMEM one cycle after that. The acc strobe
  // follows a PMEM read by one cycle for the same reason.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_d   <= 1'b0;
      wr_d    <= 1'b0;
      acc_d   <= 1'b0;
      pop_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      byp_d <= ofifo_rd;
      wr_d  <= byp_d;
      acc_d <= rd_q;
      if (launch) begin
        pop_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (ofifo_rd) pop_cnt <= pop_cnt + cnt_w'(1);
        if (wr_d)     wr_cnt  <= wr_cnt + cnt_w'(1);
      end
    end
  end

  // Only one of these sources is active in any cycle; otherwise the address
  // bus rests at 0.
  always_comb begin
    pmem_addr = '0;
    if (wr_d)          pmem_addr = addr_bw'(wr_cnt);
    else if (acc_wr_q) pmem_addr = wr_addr;
    else if (rd_q)     pmem_addr = rd_addr;
  end

  assign bus.ofifo_rd   = ofifo_rd;
  assign bus.sfu_bypass = byp_d;
  assign bus.sfu_acc    = acc_d;
  assign bus.pmem_rd    = rd_q;
  assign bus.pmem_wr    = wr_d | acc_wr_q;
  assign bus.pmem_addr  = pmem_addr;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
